// File: rtl/pe_group_ctrl_pkg.sv
// Shared types and constants for the PE_Group tile sequencer.
// Optional weight reuse is enabled by defining PE_CTRL_WEIGHT_REUSE_EN.
package pe_ctrl_pkg;

  localparam int DataInWidth = 8;
  localparam int I_Width     = 4;
  localparam int J_Width     = 4;
  localparam int RowCntWidth = 8;

  localparam int NUM_PE  = I_Width * J_Width;
  localparam int I_LANES = I_Width + J_Width - 1;

  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BEAT_CNT_W = cntWidth(I_Width + J_Width);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrlState_e;

endpackage

// File: rtl/pe_group_ctrl_if.sv
// Command, source-buffer and array-side signals of the tile sequencer.
// The reuse_w port exists only when PE_CTRL_WEIGHT_REUSE_EN is defined.
interface pe_group_ctrl_if;
  import pe_ctrl_pkg::*;

  logic                                 start;
  logic [RowCntWidth-1:0]               cfg_rows;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
  logic                                 reuse_w;
`endif
  logic                                 busy;
  logic                                 done;

  logic                                 w_src_valid;
  logic                                 w_src_rdy;
  logic [DataInWidth*J_Width-1:0]       w_src_data;
  logic                                 i_src_valid;
  logic                                 i_src_rdy;
  logic [DataInWidth*I_LANES-1:0]       i_src_data;

  logic [NUM_PE-1:0]                    arr_w_valid;
  logic [NUM_PE-1:0]                    arr_w_rdy;
  logic [DataInWidth*J_Width-1:0]       arr_w_data;
  logic [NUM_PE-1:0]                    arr_i_valid;
  logic [NUM_PE-1:0]                    arr_i_rdy;
  logic [DataInWidth*I_LANES-1:0]       arr_i_data;
  logic [NUM_PE-1:0]                    arr_o_nop;

  // master is the sequencer, slave is the surrounding buffers and array
  modport master (
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    input  reuse_w,
`endif
    input  start, cfg_rows,
    input  w_src_valid, w_src_data, i_src_valid, i_src_data,
    input  arr_w_rdy, arr_i_rdy,
    output busy, done, w_src_rdy, i_src_rdy,
    output arr_w_valid, arr_w_data, arr_i_valid, arr_i_data, arr_o_nop
  );

  modport slave (
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    output reuse_w,
`endif
    output start, cfg_rows,
    output w_src_valid, w_src_data, i_src_valid, i_src_data,
    output arr_w_rdy, arr_i_rdy,
    input  busy, done, w_src_rdy, i_src_rdy,
    input  arr_w_valid, arr_w_data, arr_i_valid, arr_i_data, arr_o_nop
  );

endinterface

// File: rtl/pe_group_ctrl.sv
// Tile sequencer for the 4x4 PE_Group: weight load, input stream, skew drain.
// Define PE_CTRL_WEIGHT_REUSE_EN to allow skipping the weight load on reuse_w.
module pe_group_ctrl
  import pe_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  pe_group_ctrl_if.master bus
);

  ctrlState_e             state;
  logic [RowCntWidth-1:0] rowsLeft;
  logic [BEAT_CNT_W-1:0]  beatCnt;
  logic                   busyQ;
  logic                   doneQ;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
  logic                   wLoaded;
`endif

  logic wRdyAll;
  logic iRdyAll;
  logic wAcc;
  logic iAcc;

  // Handshake paths are purely combinational so a stalled array costs no extra cycle
  assign wRdyAll = (state == LOAD_W) && (&bus.arr_w_rdy);
  assign iRdyAll = (state == STREAM) && (&bus.arr_i_rdy);
  assign wAcc    = wRdyAll && bus.w_src_valid;
  assign iAcc    = iRdyAll && bus.i_src_valid;

  assign bus.w_src_rdy   = wRdyAll;
  assign bus.i_src_rdy   = iRdyAll;
  assign bus.arr_w_valid = {NUM_PE{wAcc}};
  assign bus.arr_w_data  = bus.w_src_data;
  assign bus.arr_i_valid = {NUM_PE{iAcc}};
  assign bus.arr_i_data  = bus.i_src_data;
  assign bus.arr_o_nop   = {NUM_PE{~iAcc}};
  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rowsLeft <= '0;
      beatCnt  <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
      wLoaded  <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rowsLeft <= bus.cfg_rows;
            beatCnt  <= '0;
            busyQ    <= 1'b1;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
            if (bus.reuse_w && wLoaded)
              state <= (bus.cfg_rows == '0) ? DRAIN : STREAM;
            else
              state <= LOAD_W;
`else
            state <= LOAD_W;
`endif
          end
        end
        LOAD_W: begin
          if (wAcc) begin
            if (beatCnt == BEAT_CNT_W'(I_Width - 1)) begin
              beatCnt <= '0;
              state   <= (rowsLeft == '0) ? DRAIN : STREAM;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
              wLoaded <= 1'b1;
`endif
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (iAcc) begin
            if (rowsLeft != '0)
              rowsLeft <= rowsLeft - 1'b1;
            if (rowsLeft <= RowCntWidth'(1)) begin
              beatCnt <= '0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Hold NOP while the diagonal skew empties out of the array
          if (beatCnt == BEAT_CNT_W'(I_LANES - 1)) begin
            beatCnt <= '0;
            doneQ   <= 1'b1;
            state   <= DONE;
          end else begin
            beatCnt <= beatCnt + 1'b1;
          end
        end
        DONE: begin
          beatCnt <= '0;
          busyQ   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          beatCnt <= '0;
          busyQ   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_group_ctrl.sv
// Randomized bench for pe_group_ctrl against a beat-count reference model.
// Reuse scenarios are compiled in when PE_CTRL_WEIGHT_REUSE_EN is defined.
module tb_pe_group_ctrl;
  import pe_ctrl_pkg::*;

  logic clk;
  logic reset;

  pe_group_ctrl_if bus();

  pe_group_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what remains of the tile, counted in beats and cycles
  bit mIdle     = 1'b1;
  bit mWLoaded  = 1'b0;
  int wNeed     = 0;
  int iNeed     = 0;
  int drainLeft = 0;
  int cycleCnt  = 0;
  int startCyc  = 0;
  int lastLat   = 0;
  int doneCnt   = 0;
  int wBeats    = 0;
  int iBeats    = 0;
  int nopZero   = 0;
  int iRdySeen  = 0;

  logic [NUM_PE-1:0] allOnes;
  assign allOnes = '1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic setInputs(input int pV, input int pR);
    bus.w_src_valid = ($urandom_range(1, 100) <= pV);
    bus.i_src_valid = ($urandom_range(1, 100) <= pV);
    bus.w_src_data  = $urandom;
    bus.i_src_data  = {$urandom, $urandom};
    bus.arr_w_rdy   = '1;
    bus.arr_i_rdy   = '1;
    if ($urandom_range(1, 100) > pR) bus.arr_w_rdy[$urandom_range(0, NUM_PE-1)] = 1'b0;
    if ($urandom_range(1, 100) > pR) bus.arr_i_rdy[$urandom_range(0, NUM_PE-1)] = 1'b0;
  endtask

  // Compare one cycle at the falling edge, then advance the model to the next cycle
  task automatic tick();
    bit acc;
    @(negedge clk);
    cycleCnt++;
    if (bus.done === 1'b1) doneCnt++;
    if (bus.arr_o_nop === '0) nopZero++;
    if (bus.i_src_rdy === 1'b1) iRdySeen++;
    if (mIdle) begin
      checkVal("idle_busy", bus.busy, 0);
      checkVal("idle_done", bus.done, 0);
      checkVal("idle_wrdy", bus.w_src_rdy, 0);
      checkVal("idle_irdy", bus.i_src_rdy, 0);
      checkVal("idle_nop", bus.arr_o_nop, allOnes);
      checkVal("idle_wvalid", bus.arr_w_valid, 0);
      if (bus.start) begin
        mIdle     = 1'b0;
        wNeed     = I_Width;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        if (bus.reuse_w && mWLoaded) wNeed = 0;
`endif
        iNeed     = bus.cfg_rows;
        drainLeft = I_Width + J_Width - 1;
        startCyc  = cycleCnt;
      end
    end else begin
      checkVal("busy", bus.busy, 1);
      if (wNeed > 0) begin
        acc = bus.w_src_valid && (&bus.arr_w_rdy);
        checkVal("w_rdy", bus.w_src_rdy, &bus.arr_w_rdy);
        checkVal("w_i_rdy", bus.i_src_rdy, 0);
        checkVal("w_valid", bus.arr_w_valid, acc ? allOnes : '0);
        checkVal("w_nop", bus.arr_o_nop, allOnes);
        checkVal("w_done", bus.done, 0);
        if (acc) begin
          checkVal("w_data", bus.arr_w_data, bus.w_src_data);
          wNeed--;
          wBeats++;
          if (wNeed == 0) mWLoaded = 1'b1;
        end
      end else if (iNeed > 0) begin
        acc = bus.i_src_valid && (&bus.arr_i_rdy);
        checkVal("i_rdy", bus.i_src_rdy, &bus.arr_i_rdy);
        checkVal("i_w_rdy", bus.w_src_rdy, 0);
        checkVal("i_valid", bus.arr_i_valid, acc ? allOnes : '0);
        checkVal("i_nop", bus.arr_o_nop, acc ? '0 : allOnes);
        checkVal("i_done", bus.done, 0);
        if (acc) begin
          checkVal("i_data", bus.arr_i_data, bus.i_src_data);
          iNeed--;
          iBeats++;
        end
      end else if (drainLeft > 0) begin
        checkVal("dr_rdy", {bus.w_src_rdy, bus.i_src_rdy}, 0);
        checkVal("dr_nop", bus.arr_o_nop, allOnes);
        checkVal("dr_done", bus.done, 0);
        drainLeft--;
      end else begin
        checkVal("done_pulse", bus.done, 1);
        checkVal("done_rdy", {bus.w_src_rdy, bus.i_src_rdy}, 0);
        lastLat = cycleCnt - startCyc + 1;
        mIdle   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runTile(input int rows, input bit reuse, input int pV, input int pR,
                         input int wStall, input bit startNoise, output int lat);
    int budget;
    int donesBefore;
    int stallLeft;
    donesBefore = doneCnt;
    stallLeft   = wStall;
    wBeats = 0; iBeats = 0; nopZero = 0; iRdySeen = 0;
    setInputs(pV, pR);
    bus.start    = 1'b1;
    bus.cfg_rows = RowCntWidth'(rows);
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    bus.reuse_w  = reuse;
`else
    if (reuse) $display("note: reuse requested without weight reuse support");
`endif
    tick();
    budget = 0;
    while (!mIdle && budget < 2000) begin
      setInputs(pV, pR);
      bus.start    = startNoise ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.cfg_rows = RowCntWidth'($urandom);
      if (stallLeft > 0 && wNeed > 0) begin
        bus.arr_w_rdy[5] = 1'b0;
        stallLeft--;
      end
      tick();
      budget++;
    end
    bus.start = 1'b0;
    if (!mIdle) checkVal("tile_timeout", budget, 0);
    checkVal("done_count", doneCnt - donesBefore, 1);
    lat = lastLat;
  endtask

  int lat;
  int lat1;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_rows = '0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    bus.reuse_w = 1'b0;
`endif
    setInputs(100, 100);
    repeat (3) @(posedge clk);
    #2;
    checkVal("rst_busy", bus.busy, 0);
    checkVal("rst_done", bus.done, 0);
    checkVal("rst_nop", bus.arr_o_nop, allOnes);
    checkVal("rst_rdy", {bus.w_src_rdy, bus.i_src_rdy}, 0);
    checkVal("rst_valid", {bus.arr_w_valid, bus.arr_i_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // nominal tile
    runTile(8, 1'b0, 100, 100, 0, 1'b0, lat);
    checkVal("nom_latency", lat, 21);
    checkVal("nom_wbeats", wBeats, 4);
    checkVal("nom_ibeats", iBeats, 8);
    checkVal("nom_nop_zero", nopZero, 8);

    // bit 5 of arr_w_rdy held low for three LOAD_W cycles
    runTile(8, 1'b0, 100, 100, 3, 1'b0, lat);
    checkVal("bp_latency", lat, 24);
    checkVal("bp_wbeats", wBeats, 4);

    // zero rows
    runTile(0, 1'b0, 100, 100, 0, 1'b0, lat);
    checkVal("zero_latency", lat, 13);
    checkVal("zero_ibeats", iBeats, 0);
    checkVal("zero_irdy_seen", iRdySeen, 0);

    // start pulses while busy must be ignored
    runTile(8, 1'b0, 100, 100, 0, 1'b1, lat);
    checkVal("sb_latency", lat, 21);

`ifdef PE_CTRL_WEIGHT_REUSE_EN
    runTile(8, 1'b0, 100, 100, 0, 1'b0, lat1);
    runTile(8, 1'b1, 100, 100, 0, 1'b0, lat);
    checkVal("reuse_saving", lat1 - lat, 4);
    checkVal("reuse_wbeats", wBeats, 0);
    runTile(0, 1'b1, 100, 100, 0, 1'b0, lat);
    checkVal("reuse_zero_latency", lat, 9);
`endif

    // reset in the middle of STREAM
    setInputs(100, 100);
    bus.start = 1'b1;
    bus.cfg_rows = 8'd8;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 50 && (wNeed > 0 || iNeed > 5); n++) begin
      setInputs(100, 100);
      tick();
    end
    checkVal("mid_stream_reached", (wNeed == 0 && iNeed > 0 && !mIdle), 1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("mr_busy", bus.busy, 0);
    checkVal("mr_nop", bus.arr_o_nop, 16'hFFFF);
    checkVal("mr_wrdy", bus.w_src_rdy, 0);
    checkVal("mr_irdy", bus.i_src_rdy, 0);
    checkVal("mr_done", bus.done, 0);
    mIdle = 1'b1; mWLoaded = 1'b0; wNeed = 0; iNeed = 0; drainLeft = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    runTile(8, 1'b1, 100, 100, 0, 1'b0, lat);
    checkVal("post_reset_latency", lat, 21);
    checkVal("post_reset_wbeats", wBeats, 4);

    // randomized tiles with bubbles, stalls and stray starts
    for (int t = 0; t < 12; t++) begin
      runTile($urandom_range(0, 12), bit'($urandom_range(0, 1)),
              $urandom_range(40, 100), $urandom_range(50, 100), 0, 1'b1, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pe_group_ctrl.md
# pe_group_ctrl

Tile sequencer for the 4x4 `PE_Group` array. It accepts a start command with a row count, then runs one tile in three phases:
- loads I_Width weight rows into the array's W chain,
- streams cfg_rows input beats into the diagonal I chain,
- holds the O chain in NOP for the pipeline-skew drain.

It sits between the upstream weight and input buffers and the array's per-PE valid/ready/NOP vectors. It owns no datapath storage.

## Interface
- DataInWidth, 8, element width
- I_Width, 4, PE rows
- J_Width, 4, PE columns
- RowCntWidth, 8, width of the tile row counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  tile start; sampled only in IDLE
- cfg_rows  in  RowCntWidth  input beats per tile; captured on accepted start
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse at tile end
- w_src_valid, w_src_rdy  in/out  1  weight-row handshake
- w_src_data  in  DataInWidth*J_Width  one weight row per beat
- i_src_valid, i_src_rdy  in/out  1  input-beat handshake
- i_src_data  in  DataInWidth*(I_Width+J_Width-1)  one diagonal input vector per beat
- arr_w_valid  out  I_Width*J_Width  to PE_Group W_DataInValid
- arr_w_rdy  in  I_Width*J_Width  from PE_Group W_DataInRdy
- arr_w_data  out  DataInWidth*J_Width  to PE_Group W_DataIn
- arr_i_valid  out  I_Width*J_Width  to I_DataInValid
- arr_i_rdy  in  I_Width*J_Width  from I_DataInRdy
- arr_i_data  out  DataInWidth*(I_Width+J_Width-1)  to I_DataIn
- arr_o_nop  out  I_Width*J_Width  to O_NOPIn

## Operation
- **States:** IDLE, LOAD_W, STREAM, DRAIN, DONE. Encoding is 3-bit and held in a register.
- **IDLE:**
  - With start=1, capture cfg_rows into rows_left and go to LOAD_W.
  - With start=0, stay in IDLE.
- **LOAD_W:**
  - w_src_rdy = &arr_w_rdy.
  - A weight beat is accepted when w_src_valid and w_src_rdy are both high.
  - On an accepted beat, arr_w_valid = all ones for that cycle. At all other times it is zero.
  - arr_w_data = w_src_data, passed through combinationally.
  - beat_cnt counts accepted beats. After the I_Width-th accepted beat:
    - if rows_left == 0, go to DRAIN;
    - otherwise go to STREAM.
- **STREAM:**
  - i_src_rdy = &arr_i_rdy.
  - An input beat is accepted when i_src_valid and i_src_rdy are both high.
  - On an accepted beat, arr_i_valid = all ones and arr_i_data = i_src_data.
  - Each accepted beat decrements rows_left. When the last beat is accepted, go to DRAIN.
- **arr_o_nop:**
  - all zeros in a STREAM cycle that accepts a beat;
  - all ones in every other cycle (bubbles, stalls, and all other states).
- **DRAIN:** beat_cnt counts I_Width+J_Width-1 cycles unconditionally, then goes to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE. busy stays high during DONE.
- **Ready gating:** w_src_rdy and i_src_rdy are 0 outside their own phase.
- **Counters:**
  - beat_cnt is $clog2(I_Width+J_Width) bits and is cleared on every state change.
  - rows_left never wraps below 0.
- **start:** ignored in every state except IDLE.

## Timing
- **Reset values:**
  - state=IDLE, counters=0, busy=0, done=0;
  - arr_o_nop=all ones;
  - all other valid and rdy outputs 0.
- **Mid-tile reset:** reset asserted mid-tile aborts immediately. There is no done pulse, and the next start begins a fresh tile.
- **Zero-latency paths:** src→arr valid and data are combinational. arr_rdy→src_rdy is combinational.
- **No-stall latency:** start → done = 1 + I_Width + cfg_rows + (I_Width+J_Width-1) + 1 cycles. Defaults with cfg_rows=8: 21 cycles.
- **Stalls:** any arr_*_rdy bit low stalls the phase with no beat lost or duplicated.
- **done timing:** done is registered and asserts in the DONE state cycle.

## Configuration
- Macro: `PE_CTRL_WEIGHT_REUSE_EN`.
- **Defined:**
  - Adds input port reuse_w (1 bit), sampled with start.
  - Adds an internal w_loaded flag. It is set on leaving LOAD_W and cleared by reset.
  - If start accepts with reuse_w=1 and w_loaded=1, IDLE goes directly to STREAM (or DRAIN if cfg_rows=0), skipping LOAD_W.
- **Undefined:** no reuse_w port. Every tile performs LOAD_W.

## Structure
- **pe_ctrl_pkg:**
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE);
  - localparams NUM_PE = I_Width*J_Width and I_LANES = I_Width+J_Width-1;
  - counter-width function.
- **No sub-module:** a single module is sufficient.

## Test plan
- **Reset:** assert reset mid-STREAM → within the same cycle busy=0, arr_o_nop=16'hFFFF, w_src_rdy=0, i_src_rdy=0. The next start runs a full tile.
- **Nominal tile:** cfg_rows=8, sources always valid, arr rdy all ones → exactly 4 W beats and 8 I beats. arr_o_nop=0 on exactly 8 cycles. done pulses 21 cycles after start.
- **Backpressure:** in LOAD_W, clear bit 5 of arr_w_rdy for 3 cycles → w_src_rdy=0 and arr_w_valid=0 for those 3 cycles. Still exactly 4 W beats in order; done is delayed by 3 cycles.
- **Zero rows:** cfg_rows=0 → LOAD_W, then DRAIN for 7 cycles, then done. i_src_rdy never asserts.
- **Start while busy:** pulse start in STREAM → ignored; exactly one done pulse.
- **Weight reuse:** with `PE_CTRL_WEIGHT_REUSE_EN`, run a second tile with reuse_w=1 → no W beats and done 4 cycles earlier than the first tile. After a reset, reuse_w=1 still performs LOAD_W.
